// File: rtl/boot_copy_dma_pkg.sv
// boot_copy_dma_pkg: shared states, base addresses and address helpers for the boot copy engine
package boot_copy_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FLASH,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } boot_dma_state_e;

    localparam logic [31:0] FLASH_BASE = 32'h2000_0000;
    localparam logic [31:0] SRAM_BASE  = 32'h8000_0000;
    localparam logic [3:0]  BE_ALL     = 4'hF;

    // A zero-word build still needs a one-bit counter so the port is never zero width
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/boot_copy_dma_if.sv
// boot_copy_dma_if: single-outstanding OBI requester/responder bundle
interface boot_copy_dma_if;

    logic        req_o;
    logic        gnt_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;

    modport master (
        output req_o, addr_o, we_o, be_o, wdata_o,
        input  gnt_i, rvalid_i, rdata_i
    );

    modport slave (
        input  req_o, addr_o, we_o, be_o, wdata_o,
        output gnt_i, rvalid_i, rdata_i
    );

endinterface

// File: rtl/boot_copy_dma.sv
// boot_copy_dma: copies COPY_WORDS flash words into SRAM over OBI, holding the core in reset until done
module boot_copy_dma
    import boot_copy_dma_pkg::*;
#(
    parameter logic [31:0] SRC_BASE   = FLASH_BASE,
    parameter logic [31:0] DST_BASE   = SRAM_BASE,
    parameter int          COPY_WORDS = 512,
    parameter int          CNT_W      = cnt_width(COPY_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             copy_en_i,
    input  logic             flash_ready_i,
    boot_copy_dma_if.master  obi,
    output logic             busy_o,
    output logic             done_o,
    output logic             core_rst_no,
    output logic [CNT_W-1:0] words_o
);

    boot_dma_state_e  state;
    logic [CNT_W-1:0] idx_next;

    assign idx_next    = words_o + CNT_W'(1);
    assign obi.be_o    = BE_ALL;
    assign busy_o      = !(state inside {IDLE, DONE});
    assign done_o      = state == DONE;
    assign core_rst_no = done_o;

    // Copy sequencer: request fields are loaded on entry to a request state and held until the grant
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            obi.req_o   <= 1'b0;
            obi.we_o    <= 1'b0;
            obi.addr_o  <= '0;
            obi.wdata_o <= '0;
            words_o     <= '0;
        end else begin
            case (state)
                IDLE: state <= (copy_en_i && COPY_WORDS > 0) ? WAIT_FLASH : DONE;
                WAIT_FLASH: if (flash_ready_i) begin
                    state      <= RD_REQ;
                    obi.req_o  <= 1'b1;
                    obi.we_o   <= 1'b0;
                    obi.addr_o <= word_addr(SRC_BASE, 32'(words_o));
                end
                RD_REQ: if (obi.gnt_i) begin
                    state     <= RD_WAIT;
                    obi.req_o <= 1'b0;
                end
                RD_WAIT: if (obi.rvalid_i) begin
                    state       <= WR_REQ;
                    obi.req_o   <= 1'b1;
                    obi.we_o    <= 1'b1;
                    obi.addr_o  <= word_addr(DST_BASE, 32'(words_o));
                    obi.wdata_o <= obi.rdata_i;
                end
                WR_REQ: if (obi.gnt_i) begin
                    state     <= WR_WAIT;
                    obi.req_o <= 1'b0;
                end
                WR_WAIT: if (obi.rvalid_i) begin
                    words_o <= idx_next;
                    if (idx_next == CNT_W'(COPY_WORDS)) begin
                        state    <= DONE;
                        obi.we_o <= 1'b0;
                    end else begin
                        state      <= RD_REQ;
                        obi.req_o  <= 1'b1;
                        obi.we_o   <= 1'b0;
                        obi.addr_o <= word_addr(SRC_BASE, 32'(idx_next));
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_copy_dma.sv
// tb_boot_copy_dma: randomized OBI slave plus transaction-level copy model checked every cycle
module tb_boot_copy_dma;

    localparam int          N   = 4;
    localparam logic [31:0] SRC = 32'h2000_0000;
    localparam logic [31:0] DST = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, copy_en = 1'b0, flash_ready = 1'b0;
    logic busy, done, core_rst_n;
    logic [2:0] words;
    logic busy0, done0, core_rst_n0;
    logic [0:0] words0;

    boot_copy_dma_if obi();
    boot_copy_dma_if obi0();

    assign obi0.gnt_i    = 1'b0;
    assign obi0.rvalid_i = 1'b0;
    assign obi0.rdata_i  = '0;

    boot_copy_dma #(.COPY_WORDS(N)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .copy_en_i(copy_en), .flash_ready_i(flash_ready),
        .obi(obi), .busy_o(busy), .done_o(done), .core_rst_no(core_rst_n), .words_o(words)
    );

    boot_copy_dma #(.COPY_WORDS(0)) u_zero (
        .clk_i(clk), .rst_ni(rst_n), .copy_en_i(1'b1), .flash_ready_i(1'b1),
        .obi(obi0), .busy_o(busy0), .done_o(done0), .core_rst_no(core_rst_n0), .words_o(words0)
    );

    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    logic [31:0] flash [N];
    logic [31:0] sram  [N];
    int max_lat = 0;

    function automatic int lat();
        return (max_lat == 0) ? 0 : int'($urandom_range(max_lat, 0));
    endfunction

    // behavioural model: which word we are on, whether its read or write is next, whether one is outstanding
    bit m_idle = 1, m_busy = 0, m_done = 0, m_fok = 0, m_out = 0, m_wr = 0;
    bit m0_idle = 1, m0_done = 0;
    int m_words = 0;
    int rel = 0, done_cyc = -1, busy_cnt = 0, txn_cnt = 0, wr_gnt_cnt = 0;
    bit first_seen = 0;
    logic [31:0] first_addr = '0;

    bit pend = 0, pend_we = 0, er, g, r;
    int pend_idx = 0, gwait = 0, rwait = 0, widx;
    logic p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0, rd;

    always @(negedge clk) begin
        if (m_idle) begin
            chk("idle_req", 32'(obi.req_o), 0);
            chk("idle_we", 32'(obi.we_o), 0);
            chk("idle_addr", obi.addr_o, 0);
            chk("idle_wdata", obi.wdata_o, 0);
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("core_rst_n", 32'(core_rst_n), 32'(m_done));
        chk("words", 32'(words), 32'(m_words));
        chk("be", 32'(obi.be_o), 32'hF);
        er = m_busy && m_fok && !m_out;
        chk("req", 32'(obi.req_o), 32'(er));
        if (obi.req_o && er) begin
            chk("we", 32'(obi.we_o), 32'(m_wr));
            chk("addr", obi.addr_o, (m_wr ? DST : SRC) + 32'(m_words) * 4);
            if (m_wr && m_words < N) chk("wdata", obi.wdata_o, flash[m_words]);
        end
        if (obi.req_o && p_req && !p_gnt) begin
            chk("stable_addr", obi.addr_o, p_addr);
            chk("stable_we", 32'(obi.we_o), 32'(p_we));
            chk("stable_wdata", obi.wdata_o, p_wdata);
        end
        chk("zero_req", 32'(obi0.req_o), 0);
        chk("zero_done", 32'(done0), 32'(m0_done));
        chk("zero_core_rst_n", 32'(core_rst_n0), 32'(m0_done));
        chk("zero_busy", 32'(busy0), 0);
        if (done && done_cyc < 0) done_cyc = rel;
        if (busy) busy_cnt++;
        p_req = obi.req_o; p_addr = obi.addr_o; p_we = obi.we_o; p_wdata = obi.wdata_o;
        g = 0; r = 0; rd = $urandom;
        if (!rst_n) begin
            pend = 0; gwait = lat(); txn_cnt = 0; wr_gnt_cnt = 0; first_seen = 0;
            for (int k = 0; k < N; k++) sram[k] = '0;
        end else if (pend) begin
            if (rwait == 0) begin
                r = 1; pend = 0;
                if (!pend_we && pend_idx < N) rd = flash[pend_idx];
            end else rwait--;
        end else if (obi.req_o) begin
            if (gwait == 0) begin
                g = 1; pend = 1; pend_we = obi.we_o; txn_cnt++;
                widx = int'((obi.addr_o - (obi.we_o ? DST : SRC)) >> 2);
                pend_idx = widx;
                if (!first_seen) begin first_seen = 1; first_addr = obi.addr_o; end
                if (obi.we_o) begin
                    wr_gnt_cnt++;
                    if (widx >= 0 && widx < N) sram[widx] = obi.wdata_o;
                end
                rwait = lat(); gwait = lat();
            end else gwait--;
        end
        obi.gnt_i = g; obi.rvalid_i = r; obi.rdata_i = rd;
        p_gnt = g;
        if (!rst_n) begin
            m_idle = 1; m_busy = 0; m_done = 0; m_fok = 0; m_out = 0; m_wr = 0; m_words = 0;
            m0_idle = 1; m0_done = 0; rel = 0; done_cyc = -1; busy_cnt = 0;
        end else begin
            rel++;
            if (m_idle) begin
                m_idle = 0;
                if (copy_en) m_busy = 1; else m_done = 1;
            end else if (m_busy && !m_fok) m_fok = flash_ready;
            else if (m_busy) begin
                if (g) m_out = 1;
                if (r) begin
                    m_out = 0;
                    if (m_wr) begin
                        m_words++;
                        if (m_words == N) begin m_busy = 0; m_done = 1; end
                    end
                    m_wr = !m_wr;
                end
            end
            if (m0_idle) begin m0_idle = 0; m0_done = 1; end
        end
    end

    task automatic start(input bit en, input bit rdy);
        @(posedge clk); #1;
        rst_n = 0; copy_en = en; flash_ready = rdy;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        chk({name, "_timeout"}, 32'(n < 2000), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_sram(input string name);
        for (int k = 0; k < N; k++) chk(name, sram[k], flash[k]);
        chk({name, "_words"}, 32'(words), N);
    endtask

    initial begin
        flash[0] = 32'h1111_1111; flash[1] = 32'h2222_2222;
        flash[2] = 32'h3333_3333; flash[3] = 32'h4444_4444;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(obi.req_o), 0);
        chk("rst_addr", obi.addr_o, 0);
        chk("rst_wdata", obi.wdata_o, 0);
        chk("rst_be", 32'(obi.be_o), 32'hF);
        chk("rst_core_rst_n", 32'(core_rst_n), 0);
        chk("rst_words", 32'(words), 0);

        start(0, 1);
        wait_done("skip");
        repeat (5) @(posedge clk);
        #1;
        chk("skip_done_cycle", 32'(done_cyc), 1);
        chk("skip_txns", 32'(txn_cnt), 0);
        chk("skip_core_rst_n", 32'(core_rst_n), 1);
        chk("zero_words_done", 32'(done0), 1);

        start(1, 1);
        wait_done("basic");
        chk("basic_done_cycle", 32'(done_cyc), 18);
        chk("basic_busy_cycles", 32'(busy_cnt), 17);
        chk("basic_txns", 32'(txn_cnt), 8);
        chk("basic_sram0", sram[0], 32'h1111_1111);
        chk("basic_sram3", sram[3], 32'h4444_4444);
        check_sram("basic_sram");

        start(1, 0);
        repeat (21) @(posedge clk);
        #1;
        chk("fwait_txns", 32'(txn_cnt), 0);
        chk("fwait_busy", 32'(busy), 1);
        chk("fwait_core_rst_n", 32'(core_rst_n), 0);
        chk("fwait_req", 32'(obi.req_o), 0);
        flash_ready = 1;
        @(posedge clk); #1;
        chk("fwait_first_req", 32'(obi.req_o), 1);
        chk("fwait_first_addr", obi.addr_o, SRC);
        flash_ready = 0;
        wait_done("fwait");
        check_sram("fwait_sram");

        max_lat = 5;
        for (int i = 0; i < 4; i++) begin
            start(1, 1);
            for (int k = 0; k < N; k++) flash[k] = $urandom;
            wait_done("bp");
            chk("bp_txns", 32'(txn_cnt), 8);
            check_sram("bp_sram");
        end

        max_lat = 3;
        start(1, 1);
        for (int k = 0; k < N; k++) flash[k] = $urandom;
        begin
            int n = 0;
            while (wr_gnt_cnt < 3 && n < 2000) begin @(posedge clk); n++; end
            chk("midrst_timeout", 32'(n < 2000), 1);
        end
        #1 rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_req", 32'(obi.req_o), 0);
        chk("midrst_we", 32'(obi.we_o), 0);
        chk("midrst_addr", obi.addr_o, 0);
        chk("midrst_wdata", obi.wdata_o, 0);
        chk("midrst_words", 32'(words), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_core_rst_n", 32'(core_rst_n), 0);
        rst_n = 1;
        wait_done("midrst");
        chk("midrst_restart_addr", first_addr, SRC);
        check_sram("midrst_sram");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
